div_ctrl: RTL

Control unit for the iterative restoring divider. Sequences one WIDTH-bit unsigned division by driving the load and shift controls of the dividend/quotient shift register (X) and the remainder register (R). It consumes X's MSB and the remainder-versus-divisor comparator result, and reports completion or divide-by-zero to the requester through a level-sensitive go/done handshake.

---
 rtl/div_pkg.sv | 16 +
 rtl/div_ctrl_if.sv | 26 ++
 rtl/div_cnt.sv | 28 ++
 rtl/div_ctrl.sv | 108 ++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the iterative restoring divider: controller state
// encoding and the default operand width.
package div_pkg;

    localparam int DIV_WIDTH = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT_R,
        S_TEST,
        S_DONE,
        S_ERR
    } div_state_t;

endpackage

// File: rtl/div_ctrl_if.sv
// Requester-side go/done handshake of the divider controller.
interface div_ctrl_if;

    logic go;
    logic y_is_zero;
    logic busy;
    logic done;
    logic err;

    modport master (
        output go,
        output y_is_zero,
        input  busy,
        input  done,
        input  err
    );

    modport slave (
        input  go,
        input  y_is_zero,
        output busy,
        output done,
        output err
    );

endinterface

// File: rtl/div_cnt.sv
// Loadable down-counter for the divider iteration count, flagging the last
// iteration (count of one).
module div_cnt #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] ld_val,
    output logic         is_one
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= ld_val;
        end else if (dec) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign is_one = (cnt == W'(1));

endmodule

// File: rtl/div_ctrl.sv
// Sequencer for a WIDTH-bit restoring divider: drives X/R load and shift
// controls and reports done / divide-by-zero over a level go/done handshake.
module div_ctrl
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic       clk,
    input  logic       rst_n,
    div_ctrl_if.slave  req,
    input  logic       r_lt_y,
    input  logic       x_msb,
    output logic       x_ld,
    output logic       x_sl,
    output logic       x_sh_b,
    output logic       r_clr,
    output logic       r_sl,
    output logic       r_sh_b,
    output logic       r_ld_sub
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);

    div_state_t state;
    div_state_t state_nx;
    logic       cnt_last;
    logic       busy_o;
    logic       done_o;
    logic       err_o;

    div_cnt #(
        .W (CNT_W)
    ) u_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (state == S_LOAD),
        .dec    (state == S_TEST),
        .ld_val (CNT_INIT),
        .is_one (cnt_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (req.go) begin
                    state_nx = req.y_is_zero ? S_ERR : S_LOAD;
                end
            end
            S_LOAD:    state_nx = S_SHIFT_R;
            S_SHIFT_R: state_nx = S_TEST;
            // cnt still holds this iteration's value; one means this is the last
            S_TEST:    state_nx = cnt_last ? S_DONE : S_SHIFT_R;
            S_DONE:    if (!req.go) state_nx = S_IDLE;
            S_ERR:     if (!req.go) state_nx = S_IDLE;
            default:   state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        x_ld     = 1'b0;
        x_sl     = 1'b0;
        x_sh_b   = 1'b0;
        r_clr    = 1'b0;
        r_sl     = 1'b0;
        r_sh_b   = 1'b0;
        r_ld_sub = 1'b0;
        busy_o   = 1'b0;
        done_o   = 1'b0;
        err_o    = 1'b0;
        case (state)
            S_LOAD: begin
                x_ld   = 1'b1;
                r_clr  = 1'b1;
                busy_o = 1'b1;
            end
            S_SHIFT_R: begin
                r_sl   = 1'b1;
                r_sh_b = x_msb;
                busy_o = 1'b1;
            end
            // Restoring step: subtract only when the partial remainder fits
            S_TEST: begin
                x_sl     = 1'b1;
                x_sh_b   = ~r_lt_y;
                r_ld_sub = ~r_lt_y;
                busy_o   = 1'b1;
            end
            S_DONE:  done_o = 1'b1;
            S_ERR:   err_o  = 1'b1;
            default: ;
        endcase
    end

    assign req.busy = busy_o;
    assign req.done = done_o;
    assign req.err  = err_o;

endmodule
